// File: rtl/proj_mem_pkg.sv
// Shared definitions for the projection-weight memory.
// Holds the power-state encoding and the default geometry / wake timing
// used by proj_mem_pm and proj_mem_pwr_fsm.
package proj_mem_pkg;

  // Power-state encoding is visible on the PSTATE port, so values are fixed.
  typedef enum logic [1:0] {
    PS_ACT  = 2'd0,
    PS_SLP  = 2'd1,
    PS_SD   = 2'd2,
    PS_WAKE = 2'd3
  } pstate_t;

  localparam int DEF_NUM_WORD      = 128;
  localparam int DEF_NUM_BIT       = 128;
  localparam int DEF_NUM_WORD_ADDR = 7;
  localparam int DEF_WAKE_CYC      = 4;

endpackage

// File: rtl/proj_mem_pwr_fsm.sv
// Power-state machine for the projection memory.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (resets into WAKE)
//   slp, sd     level-sensitive sleep / shutdown requests (sd wins)
//   rdy         registered, 1 only while in ACT
//   pstate      registered current power state
//   sd_entry    high in the cycle whose closing edge moves the FSM into SD;
//               the memory uses that edge to drop contents validity and Q
module proj_mem_pwr_fsm
  import proj_mem_pkg::*;
#(
  parameter int WAKE_CYC = DEF_WAKE_CYC
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    slp,
  input  logic    sd,
  output logic    rdy,
  output pstate_t pstate,
  output logic    sd_entry
);

  localparam int CW = $clog2(WAKE_CYC + 1);

  logic [CW-1:0] wake_cnt;
  pstate_t       nxt;

  always_comb begin
    nxt = pstate;
    unique case (pstate)
      PS_ACT: begin
        if (sd)       nxt = PS_SD;
        else if (slp) nxt = PS_SLP;
      end
      PS_SLP: begin
        if (sd)        nxt = PS_SD;
        else if (!slp) nxt = PS_WAKE;
      end
      PS_SD: begin
        if (!sd) nxt = slp ? PS_SLP : PS_WAKE;
      end
      PS_WAKE: begin
        if (sd)                      nxt = PS_SD;
        else if (slp)                nxt = PS_SLP;
        else if (wake_cnt == CW'(1)) nxt = PS_ACT;
      end
      default: nxt = PS_WAKE;
    endcase
  end

  assign sd_entry = (nxt == PS_SD) && (pstate != PS_SD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate   <= PS_WAKE;
      rdy      <= 1'b0;
      wake_cnt <= CW'(WAKE_CYC);
    end else begin
      pstate <= nxt;
      rdy    <= (nxt == PS_ACT);
      // Every entry into WAKE restarts the full wake interval.
      if (nxt == PS_WAKE && pstate != PS_WAKE)
        wake_cnt <= CW'(WAKE_CYC);
      else if (pstate == PS_WAKE)
        wake_cnt <= wake_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/proj_mem_pm.sv
// Parametrised single-port projection-weight SRAM with power management.
// Ports:
//   CLK, RSTB            clock, asynchronous active-low reset
//   BIST                 1 = use the M-suffixed (BIST) port, 0 = normal port
//   SLP, SD              sleep / shutdown requests (level, SD has priority)
//   CEB/WEB/A/D/BWEB     normal port: chip enable, write enable (0 = write),
//                        address, data, per-bit write enable (all active-low)
//   CEBM/WEBM/AM/DM/BWEBM  BIST port equivalents
//   RTSEL, WTSEL         timing selects, registered only
//   Q, QV                read data and its one-cycle valid pulse
//   RDY, PSTATE          access-ready flag and current power state
// Handshake: an access is taken on a rising edge when RDY=1 and the selected
// CE is low; with RDY=0 the request is ignored (never queued), so the
// requester simply holds it until it sees RDY=1 on that edge.
module proj_mem_pm
  import proj_mem_pkg::*;
#(
  parameter int NUM_WORD      = DEF_NUM_WORD,
  parameter int NUM_BIT       = DEF_NUM_BIT,
  parameter int NUM_WORD_ADDR = DEF_NUM_WORD_ADDR,
  parameter int WAKE_CYC      = DEF_WAKE_CYC,
  parameter int READ_LAT      = 1
) (
  input  logic                     CLK,
  input  logic                     RSTB,
  input  logic                     BIST,
  input  logic                     SLP,
  input  logic                     SD,
  input  logic                     CEB,
  input  logic                     WEB,
  input  logic [NUM_WORD_ADDR-1:0] A,
  input  logic [NUM_BIT-1:0]       D,
  input  logic [NUM_BIT-1:0]       BWEB,
  input  logic                     CEBM,
  input  logic                     WEBM,
  input  logic [NUM_WORD_ADDR-1:0] AM,
  input  logic [NUM_BIT-1:0]       DM,
  input  logic [NUM_BIT-1:0]       BWEBM,
  input  logic [1:0]               RTSEL,
  input  logic [1:0]               WTSEL,
  output logic [NUM_BIT-1:0]       Q,
  output logic                     QV,
  output logic                     RDY,
  output logic [1:0]               PSTATE
);

  localparam logic [NUM_WORD_ADDR:0] WORDS = (NUM_WORD_ADDR+1)'(NUM_WORD);

  // Selected port
  logic                     ce, we;
  logic [NUM_WORD_ADDR-1:0] a;
  logic [NUM_BIT-1:0]       d, bw;

  assign ce = BIST ? CEBM  : CEB;
  assign we = BIST ? WEBM  : WEB;
  assign a  = BIST ? AM    : A;
  assign d  = BIST ? DM    : D;
  assign bw = BIST ? BWEBM : BWEB;

  logic accept, wr_en, rd_en, in_range;
  assign accept   = RDY & ~ce;
  assign wr_en    = accept & ~we;
  assign rd_en    = accept & we;
  assign in_range = {1'b0, a} < WORDS;

  // Power FSM
  pstate_t pstate;
  logic    sd_entry;

  proj_mem_pwr_fsm #(.WAKE_CYC(WAKE_CYC)) u_pwr (
    .clk      (CLK),
    .rst_n    (RSTB),
    .slp      (SLP),
    .sd       (SD),
    .rdy      (RDY),
    .pstate   (pstate),
    .sd_entry (sd_entry)
  );

  assign PSTATE = pstate;

  // Array: contents survive reset, so no reset branch here.
  logic [NUM_BIT-1:0] mem [NUM_WORD];

  always_ff @(posedge CLK) begin
    if (wr_en && in_range)
      mem[a] <= (mem[a] & bw) | (d & ~bw);
  end

  // Read pipeline. Stage 1 holds the accepted address; the array is looked
  // up one edge after acceptance, so a write in the cycle just before the
  // read is already visible. Stage 2 only matters for READ_LAT=2.
  logic [NUM_WORD-1:0]      valid;
  logic                     rd_v;
  logic [NUM_WORD_ADDR-1:0] rd_a;
  logic                     s2_v;
  logic [NUM_BIT-1:0]       s2_d;
  logic                     rd_in_range;
  logic [NUM_BIT-1:0]       rdata;
  logic                     out_v;
  logic [NUM_BIT-1:0]       out_d;
  logic [3:0]               timing_sel_unused;

  assign rd_in_range = {1'b0, rd_a} < WORDS;
  assign rdata       = (rd_in_range && valid[rd_a]) ? mem[rd_a] : '0;
  assign out_v       = (READ_LAT == 2) ? s2_v : rd_v;
  assign out_d       = (READ_LAT == 2) ? s2_d : rdata;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      valid             <= '0;
      rd_v              <= 1'b0;
      rd_a              <= '0;
      s2_v              <= 1'b0;
      s2_d              <= '0;
      Q                 <= '0;
      QV                <= 1'b0;
      timing_sel_unused <= '0;
    end else begin
      timing_sel_unused <= {RTSEL, WTSEL};
      rd_v <= rd_en;
      rd_a <= a;
      s2_v <= rd_v;
      s2_d <= rdata;
      if (wr_en && in_range)
        valid[a] <= 1'b1;
      QV <= out_v;
      if (out_v)
        Q <= out_d;
      // Shutdown entry overrides everything landing on the same edge:
      // contents become invalid and every read still in flight is dropped.
      if (sd_entry) begin
        valid <= '0;
        rd_v  <= 1'b0;
        s2_v  <= 1'b0;
        Q     <= '0;
        QV    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proj_mem_pm.sv
module tb_proj_mem_pm;

  localparam int NB = 128;
  localparam int AW = 7;
  localparam int WAKE = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RSTB, BIST, SLP, SD, CEB, WEB, CEBM, WEBM;
  logic [AW-1:0] A, AM;
  logic [NB-1:0] D, BWEB, DM, BWEBM;
  logic [1:0]    RTSEL, WTSEL;

  logic [NB-1:0] q0, q1;
  logic          qv0, qv1, rdy0, rdy1;
  logic [1:0]    pst0, pst1;

  // dut0: full 128-word array, 1-cycle read; dut1: 100 words, 2-cycle read.
  proj_mem_pm #(.NUM_WORD(128), .READ_LAT(1)) dut0 (
    .CLK(CLK), .RSTB(RSTB), .BIST(BIST), .SLP(SLP), .SD(SD),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
    .CEBM(CEBM), .WEBM(WEBM), .AM(AM), .DM(DM), .BWEBM(BWEBM),
    .RTSEL(RTSEL), .WTSEL(WTSEL),
    .Q(q0), .QV(qv0), .RDY(rdy0), .PSTATE(pst0)
  );

  proj_mem_pm #(.NUM_WORD(100), .READ_LAT(2)) dut1 (
    .CLK(CLK), .RSTB(RSTB), .BIST(BIST), .SLP(SLP), .SD(SD),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
    .CEBM(CEBM), .WEBM(WEBM), .AM(AM), .DM(DM), .BWEBM(BWEBM),
    .RTSEL(RTSEL), .WTSEL(WTSEL),
    .Q(q1), .QV(qv1), .RDY(rdy1), .PSTATE(pst1)
  );

  // ---------------- checker ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            k;
    int            due;
    logic [NB-1:0] data;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  logic [NB-1:0] m_mem [2][128];
  bit            m_valid [2][128];
  logic [NB-1:0] m_q [2];
  bit            m_qv [2];
  int            m_pst, m_wake, cyc;

  function automatic int nw(input int k);
    return (k == 0) ? 128 : 100;
  endfunction

  function automatic int rl(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_pst  = 3;
    m_wake = WAKE;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      m_q[k]  = '0;
      m_qv[k] = 0;
      for (int w = 0; w < 128; w++) m_valid[k][w] = 0;
    end
  endtask

  // One rising edge of the behavioural model, using the inputs as they are now.
  task automatic model_step();
    logic          ce, we;
    logic [AW-1:0] a;
    logic [NB-1:0] d, bw, rd;
    int            nxt, i;
    bit            sd_in, acc;
    ce = BIST ? CEBM : CEB;
    we = BIST ? WEBM : WEB;
    a  = BIST ? AM : A;
    d  = BIST ? DM : D;
    bw = BIST ? BWEBM : BWEB;
    if (SD) nxt = 2;
    else if (SLP) nxt = 1;
    else if (m_pst == 0) nxt = 0;
    else if (m_pst == 3) nxt = (m_wake == 1) ? 0 : 3;
    else nxt = 3;
    sd_in = (nxt == 2) && (m_pst != 2);
    acc   = (m_pst == 0) && !ce;
    cyc++;
    m_qv[0] = 0;
    m_qv[1] = 0;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].due == cyc) begin
        if (!sd_in) begin
          m_q[exp_q[i].k]  = exp_q[i].data;
          m_qv[exp_q[i].k] = 1;
        end
        exp_q.delete(i);
      end else i++;
    end
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        if (we) begin
          rd = (int'(a) < nw(k) && m_valid[k][a]) ? m_mem[k][a] : '0;
          if (!sd_in) exp_q.push_back('{k, cyc + rl(k), rd});
        end else if (int'(a) < nw(k)) begin
          m_mem[k][a]   = (m_mem[k][a] & bw) | (d & ~bw);
          m_valid[k][a] = 1;
        end
      end
    end
    if (sd_in) begin
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
        m_q[k]  = '0;
        m_qv[k] = 0;
        for (int w = 0; w < 128; w++) m_valid[k][w] = 0;
      end
    end
    if (nxt == 3 && m_pst != 3) m_wake = WAKE;
    else if (m_pst == 3) m_wake--;
    m_pst = nxt;
  endtask

  task automatic check_all();
    chk("rdy0", NB'(rdy0), NB'(m_pst == 0));
    chk("rdy1", NB'(rdy1), NB'(m_pst == 0));
    chk("pst0", NB'(pst0), NB'(m_pst));
    chk("pst1", NB'(pst1), NB'(m_pst));
    chk("qv0", NB'(qv0), NB'(m_qv[0]));
    chk("qv1", NB'(qv1), NB'(m_qv[1]));
    chk("q0", q0, m_q[0]);
    chk("q1", q1, m_q[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    if (RSTB) model_step();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    BIST = 0; CEB = 1; WEB = 1; CEBM = 1; WEBM = 1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] d, input logic [NB-1:0] bw);
    CEB = 0; WEB = 0; A = a; D = d; BWEB = bw;
    cycle();
    set_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    CEB = 0; WEB = 1; A = a;
    cycle();
    set_idle();
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 50 && rdy0 !== 1'b1; i++) cycle();
    chk("rdy_wait", NB'(rdy0), NB'(1));
  endtask

  function automatic logic [NB-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  logic [NB-1:0] w5;

  initial begin
    RSTB = 0; SLP = 0; SD = 0; A = '0; AM = '0; D = '0; DM = '0;
    BWEB = '0; BWEBM = '0; RTSEL = 2'd0; WTSEL = 2'd0;
    set_idle();
    cyc = 0;
    model_reset();
    cycle();
    cycle();
    chk("rst_q0", q0, '0);
    chk("rst_qv0", NB'(qv0), '0);
    chk("rst_rdy0", NB'(rdy0), '0);
    chk("rst_pst0", NB'(pst0), NB'(3));
    RSTB = 1;

    // wake: RDY low for four cycles, high on the fifth
    chk("wake_rdy_c1", NB'(rdy0), '0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wake_rdy_lo", NB'(rdy0), '0);
    end
    cycle();
    chk("wake_rdy_hi", NB'(rdy0), NB'(1));
    chk("wake_pst_act", NB'(pst0), '0);

    // fill the array so every word has a known value
    for (int w = 0; w < 128; w++)
      do_write(AW'(w), (w == 5) ? '0 : rnd128(), '0);

    // masked write over a zero word
    do_write(7'd5, {NB{1'b1}}, {{(NB-8){1'b1}}, 8'h00});
    do_read(7'd5);
    cycle();
    chk("mask_q0", q0, NB'(8'hFF));
    chk("mask_qv0", NB'(qv0), NB'(1));
    chk("mask_qv1_early", NB'(qv1), '0);
    cycle();
    chk("mask_q1", q1, NB'(8'hFF));
    chk("mask_qv1", NB'(qv1), NB'(1));
    chk("mask_qv0_once", NB'(qv0), '0);

    // back-to-back reads
    for (int i = 1; i <= 3; i++) begin
      CEB = 0; WEB = 1; A = AW'(i);
      cycle();
    end
    set_idle();
    for (int i = 0; i < 3; i++) cycle();

    // sleep with writes attempted throughout
    SLP = 1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      CEB = 0; WEB = 0; A = 7'd5; D = rnd128(); BWEB = '0;
      cycle();
      chk("slp_rdy", NB'(rdy0), '0);
    end
    set_idle();
    SLP = 0;
    cycle();
    chk("slp_wake", NB'(pst0), NB'(3));
    wait_rdy();
    do_read(7'd5);
    cycle();
    chk("slp_keep_q0", q0, NB'(8'hFF));
    cycle();

    // shutdown + sleep together
    SD = 1; SLP = 1;
    cycle();
    chk("sd_pst", NB'(pst0), NB'(2));
    chk("sd_q0", q0, '0);
    chk("sd_q1", q1, '0);
    SD = 0; SLP = 0;
    wait_rdy();
    do_read(7'd5);
    cycle();
    chk("sd_lost_q0", q0, '0);
    chk("sd_lost_qv0", NB'(qv0), NB'(1));
    cycle();
    w5 = rnd128();
    do_write(7'd5, w5, '0);
    do_read(7'd5);
    cycle();
    chk("sd_new_q0", q0, w5);
    cycle();

    // BIST port write while the normal port also requests
    BIST = 1; CEBM = 0; WEBM = 0; AM = 7'd127; DM = {16{8'hA5}}; BWEBM = '0;
    CEB = 0; WEB = 0; A = 7'd127; D = {16{8'h5A}}; BWEB = '0;
    cycle();
    set_idle();
    do_read(7'd127);
    cycle();
    chk("bist_q0", q0, {16{8'hA5}});
    cycle();
    chk("oor_q1", q1, '0);
    chk("oor_qv1", NB'(qv1), NB'(1));

    // randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) SLP = ~SLP;
      if ($urandom_range(0, 79) == 0) SD = ~SD;
      BIST  = ($urandom_range(0, 3) == 0);
      CEB   = ($urandom_range(0, 9) < 3);
      CEBM  = ($urandom_range(0, 9) < 3);
      WEB   = $urandom_range(0, 1);
      WEBM  = $urandom_range(0, 1);
      A     = AW'($urandom_range(0, 127));
      AM    = AW'($urandom_range(0, 127));
      D     = rnd128();
      DM    = rnd128();
      BWEB  = ($urandom_range(0, 1) == 0) ? '0 : rnd128();
      BWEBM = ($urandom_range(0, 1) == 0) ? '0 : rnd128();
      RTSEL = 2'($urandom_range(0, 3));
      WTSEL = 2'($urandom_range(0, 3));
      cycle();
    end
    set_idle();
    SLP = 0; SD = 0;
    wait_rdy();

    // reset falling right after a read is accepted
    CEB = 0; WEB = 1; A = 7'd5;
    @(posedge CLK);
    model_step();
    #1;
    RSTB = 0;
    model_reset();
    set_idle();
    #1;
    check_all();
    chk("rstmid_qv0", NB'(qv0), '0);
    chk("rstmid_pst0", NB'(pst0), NB'(3));
    cycle();
    cycle();
    RSTB = 1;
    cycle();
    chk("rstmid_qv0_after", NB'(qv0), '0);
    chk("rstmid_qv1_after", NB'(qv1), '0);
    wait_rdy();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/proj_mem_pm.md
Name: proj_mem_pm

Overview:
- Parametrised, synthesisable single-port SRAM model for projection weights. Successor to the fixed 128x128 projection-memory macro shell.
- Adds an explicit power-state machine (active / sleep / shutdown / wake), a ready/valid access handshake, configurable read latency and per-word contents validity after shutdown.
- Sits between the projection datapath (normal port) and the memory BIST controller (M-suffixed port).

Parameters:
- NUM_WORD, 128, number of words; must be <= 2**NUM_WORD_ADDR.
- NUM_BIT, 128, data width in bits.
- NUM_WORD_ADDR, 7, address width.
- WAKE_CYC, 4, cycles spent in WAKE before accesses are accepted; must be >= 1.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTB  in  1  reset, asynchronous, active-low.
- BIST  in  1  1 selects the M-suffixed port, 0 selects the normal port; sampled every cycle.
- SLP  in  1  sleep request, level-sensitive.
- SD  in  1  shutdown request, level-sensitive; has priority over SLP.
- CEB  in  1  normal-port chip enable, active-low.
- WEB  in  1  normal-port write enable, active-low (0 = write, 1 = read).
- A  in  NUM_WORD_ADDR  normal-port address.
- D  in  NUM_BIT  normal-port write data.
- BWEB  in  NUM_BIT  normal-port bit write enable, active-low per bit.
- CEBM, WEBM, AM, DM, BWEBM  in  same widths as the normal port  BIST-port equivalents.
- RTSEL  in  2  read timing select; registered, no functional effect in this model.
- WTSEL  in  2  write timing select; registered, no functional effect in this model.
- Q  out  NUM_BIT  read data.
- QV  out  1  one-cycle pulse marking Q valid for a read.
- RDY  out  1  1 when an access may be accepted this cycle.
- PSTATE  out  2  current power state.

Behaviour:
- Reset (RSTB=0, asynchronous):
  - Q=0, QV=0, RDY=0, PSTATE=WAKE.
  - Wake counter loaded with WAKE_CYC.
  - Every word-valid bit cleared.
  - Array contents are not reset.
- Port select (combinational):
  - Selected signals are CE/WE/A/D/BW = BIST ? M-port : normal port.
  - Changing BIST has effect in the same cycle.
- Accept condition: accept = RDY & ~CE. When RDY=0, CE is ignored entirely: no write, no read, no QV.
- Write (accept & ~WE):
  - For every bit i with BW[i]=0: mem[A][i] <= D[i]. Bits with BW[i]=1 are unchanged.
  - valid[A] <= 1.
  - Q unchanged; no QV.
- Read (accept & WE):
  - With READ_LAT=1, Q and QV update at edge N+1 after acceptance at edge N.
  - With READ_LAT=2, they update at edge N+2.
  - Q = valid[A] ? mem[A] : 0.
  - QV is high for exactly one cycle per read.
  - Back-to-back reads are fully pipelined: one per cycle, in order.
  - Between reads, Q holds its last value.
- Same-address read-after-write in consecutive cycles returns the newly written data.
- Out of range address (A >= NUM_WORD):
  - Write has no effect.
  - Read returns Q=0 with QV=1.
- Power FSM (PSTATE encoding ACT=0, SLP=1, SD=2, WAKE=3). RDY=1 only in ACT.
  - ACT: SD=1 -> SD; else SLP=1 -> SLP.
  - SLP: SD=1 -> SD; SLP=0 -> WAKE. Contents and valid bits are retained; Q is held.
  - SD: on entry all valid bits are cleared and Q is set to 0. When SD=0: SLP=1 -> SLP, else -> WAKE.
  - WAKE:
    - SD=1 -> SD; SLP=1 -> SLP.
    - Otherwise decrement the counter; at 1 -> ACT.
    - The counter is reloaded with WAKE_CYC on every entry to WAKE.
  - SD and SLP asserted together: SD wins.
- In-flight reads: a read accepted in ACT always delivers its QV on schedule, even if the FSM has left ACT.
  - Exception: the SD-entry clear of Q takes precedence over a read result landing in the same cycle.
  - Any pending QV is then dropped.
- Reset mid-operation: in-flight reads are discarded and no QV is produced.

Decomposition:
- Shared package proj_mem_pkg holds:
  - the pstate_t enum (ACT, SLP, SD, WAKE);
  - default values for NUM_WORD, NUM_BIT, NUM_WORD_ADDR and WAKE_CYC.
- Sub-module proj_mem_pwr_fsm implements the power FSM and wake counter, with outputs RDY, PSTATE and a one-cycle sd_entry pulse.
- The array, valid bitmap and read pipeline stay in the top.

Test Plan:
- Reset, then hold SLP=SD=0 -> RDY=0 for 4 cycles, RDY=1 on the 5th; PSTATE goes 3 -> 0.
- Write A=5, D=all-1s, BWEB=all-1s except bits [7:0]=0, over a word holding 0. Read A=5 -> Q=0x..00FF and QV pulses 1 cycle (READ_LAT=1). With READ_LAT=2, QV arrives 2 cycles after acceptance.
- Reads at A=1,2,3 in back-to-back cycles -> three consecutive QV pulses with the matching data, in order.
- SLP=1 for 10 cycles, CEB=0 throughout -> RDY=0 and no writes. SLP=0 -> WAKE for 4 cycles, then a read of A=5 returns 0x..00FF.
- SD and SLP pulsed together -> PSTATE=2 and Q=0. After release, a read of A=5 returns 0. Write A=5, then read -> new data.
- BIST=1 with CEBM=0, WEBM=0, AM=127, DM=0xA5.., BWEBM=0, while CEB is also driven low -> M-port data is written. BIST=0 read of A=127 returns 0xA5..
- Read accepted in the same cycle RSTB falls -> no QV.
- Read at A=127 with NUM_WORD=100 -> Q=0, QV=1.
